// File: rtl/mod_exp_pkg.sv
// Shared constants, state encodings and the modular-add helper for the
// modular exponentiator and its multiplier (also reused by mod_inv via E=P-2).
package mod_exp_pkg;

    localparam int WIDTH = 256;

    // secp256k1 field prime
    localparam logic [255:0] P_SECP256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    // Multiplier: done is high this many cycles after its start cycle.
    localparam int MUL_LATENCY = 257;
    // Exponentiator: done is high this many cycles after the accepting cycle.
    localparam int EXP_LATENCY = 132097;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SQR_GO   = 3'd1,
        SQR_WAIT = 3'd2,
        MUL_GO   = 3'd3,
        MUL_WAIT = 3'd4,
        FIN      = 3'd5
    } exp_state_t;

    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_ITER  = 2'd1,
        MUL_FINAL = 2'd2
    } mul_state_t;

    // (x + y) mod p for x, y < p; the 257-bit sum keeps the carry so a single
    // conditional subtract is enough.
    function automatic logic [255:0] mod_add(input logic [255:0] x,
                                             input logic [255:0] y,
                                             input logic [255:0] p);
        logic [256:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return s[255:0];
    endfunction

endpackage

// File: rtl/mod_exp_mul.sv
// Interleaved shift-add modular multiplier: product = a*b mod P.
// One bit of b per cycle, MSB first; done pulses MUL_LATENCY cycles after start.
// Both operands must already be below P.
module mod_exp_mul
    import mod_exp_pkg::*;
#(
    parameter logic [255:0] P = P_SECP256K1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [255:0] product,
    output logic         done
);

    mul_state_t   state, state_next;
    logic [255:0] a_q, b_q, r_q;
    logic [255:0] r_dbl, r_step;
    logic [7:0]   cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= MUL_IDLE;
        else     state <= state_next;
    end

    // Next state: 256 iteration cycles, then one finalize cycle with done high
    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE:  if (start) state_next = MUL_ITER;
            MUL_ITER:  if (cnt == 8'd0) state_next = MUL_FINAL;
            MUL_FINAL: state_next = MUL_IDLE;
            default:   state_next = MUL_IDLE;
        endcase
    end

    // One Horner step: r = 2r mod P, then + a mod P when the current b bit is set
    always_comb begin
        r_dbl  = mod_add(r_q, r_q, P);
        r_step = b_q[255] ? mod_add(r_dbl, a_q, P) : r_dbl;
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
            cnt <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        r_q <= '0;
                        cnt <= 8'(MUL_LATENCY - 2);
                    end
                end
                MUL_ITER: begin
                    r_q <= r_step;
                    b_q <= {b_q[254:0], 1'b0};
                    cnt <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign product = r_q;
    assign done    = (state == MUL_FINAL);

endmodule

// File: rtl/mod_exp.sv
// Constant-time modular exponentiation R = A^E mod P, left-to-right
// square-and-multiply over all 256 exponent bits. The multiply runs for every
// bit and its result is kept only when the bit is set, so latency does not
// depend on the operands.
//
// state    | meaning
// IDLE     | waiting for start; captures A (reduced), E, acc=1
// SQR_GO   | start multiplier with acc*acc
// SQR_WAIT | wait for square, acc <= product
// MUL_GO   | start multiplier with acc*A
// MUL_WAIT | wait for multiply, keep product if E bit set, next bit or finish
// FIN      | done pulse, R = acc
module mod_exp
    import mod_exp_pkg::*;
#(
    parameter logic [255:0] P = P_SECP256K1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] A,
    input  logic [255:0] E,
    output logic [255:0] R,
    output logic         done,
    output logic         busy
);

    exp_state_t   state, state_next;
    logic [255:0] acc, a_q, e_q, r_q, acc_upd;
    logic [7:0]   idx;
    logic         mul_start, mul_done;
    logic [255:0] mul_b, mul_product;

    mod_exp_mul #(.P(P)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (acc),
        .b       (mul_b),
        .product (mul_product),
        .done    (mul_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and control outputs
    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        mul_b      = acc;
        done       = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = SQR_GO;
            end
            SQR_GO: begin
                mul_start  = 1'b1;
                state_next = SQR_WAIT;
            end
            SQR_WAIT: if (mul_done) state_next = MUL_GO;
            MUL_GO: begin
                mul_start  = 1'b1;
                mul_b      = a_q;
                state_next = MUL_WAIT;
            end
            MUL_WAIT: if (mul_done) state_next = (idx == 8'd0) ? FIN : SQR_GO;
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulator after the conditional multiply for the current exponent bit
    always_comb begin
        acc_upd = e_q[255] ? mul_product : acc;
    end

    // Operand capture, accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 256'd1;
            a_q <= '0;
            e_q <= '0;
            idx <= '0;
            r_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= 256'd1;
                        idx <= 8'd255;
                        e_q <= E;
                        a_q <= (A >= P) ? (A - P) : A;
                    end
                end
                SQR_WAIT: if (mul_done) acc <= mul_product;
                MUL_WAIT: begin
                    if (mul_done) begin
                        acc <= acc_upd;
                        e_q <= {e_q[254:0], 1'b0};
                        idx <= idx - 8'd1;
                        // Load R on the way into FIN so it is valid with done.
                        if (idx == 8'd0) r_q <= acc_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign R = r_q;

endmodule

// File: tb/tb_mod_exp.sv
// Directed bench for mod_exp with a reference model and an expected-result queue.
module tb_mod_exp;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] INV2 =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;
    localparam int LAT   = 132097;
    localparam int LIMIT = 140000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] A_in = '0;
    logic [255:0] E_in = '0;
    logic [255:0] R;
    logic         done, busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [255:0] sb[$];

    always #5 clk = ~clk;

    mod_exp dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A_in),
        .E     (E_in),
        .R     (R),
        .done  (done),
        .busy  (busy)
    );

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] t;
        logic [511:0] m;
        t = {256'd0, x} * {256'd0, y};
        m = t % {256'd0, P};
        return m[255:0];
    endfunction

    function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] e);
        logic [255:0] acc;
        logic [255:0] b;
        acc = 256'd1;
        b   = base % P;
        for (int i = 255; i >= 0; i--) begin
            acc = mulmod(acc, acc);
            if (e[i]) acc = mulmod(acc, b);
        end
        return acc;
    endfunction

    // Drives one operation from the current negedge. poke_at re-pulses start
    // with other operands at that cycle; rst_at aborts the operation there.
    task automatic do_op(input string tag, input logic [255:0] a, input logic [255:0] e,
                         input int poke_at, input int rst_at);
        int n;
        int dc0;
        logic [255:0] expv;
        A_in = a;
        E_in = e;
        start = 1'b1;
        sb.push_back(powmod(a, e));
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, "_busy_first"}, 256'(busy), 256'd1);
        while (done !== 1'b1 && n < LIMIT) begin
            if (n == poke_at) begin
                start = 1'b1;
                A_in  = ~a;
                E_in  = e + 256'd1;
            end else begin
                start = 1'b0;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({tag, "_rst_R"}, R, 256'd0);
                check({tag, "_rst_busy"}, 256'(busy), 256'd0);
                check({tag, "_rst_done"}, 256'(done), 256'd0);
                check({tag, "_rst_no_done"}, 256'(done_cnt), 256'(dc0));
                void'(sb.pop_front());
                return;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 256'(n), 256'(LAT));
        expv = sb.pop_front();
        check({tag, "_R"}, R, expv);
        check({tag, "_busy_fin"}, 256'(busy), 256'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 256'(done), 256'd0);
        check({tag, "_busy_after"}, 256'(busy), 256'd0);
        check({tag, "_R_hold"}, R, expv);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, 256'(done_cnt), 256'(dc0 + 1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_R", R, 256'd0);
        check("reset_done", 256'(done), 256'd0);
        check("reset_busy", 256'(busy), 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // Inverse of 2 via Fermat, checked against a constant and by multiplication
        do_op("inv2", 256'd2, P - 256'd2, 0, 0);
        check("inv2_const", R, INV2);
        check("inv2_times_a", mulmod(R, 256'd2), 256'd1);

        // Second start at cycle 1000 with different operands must be ignored
        do_op("pm1_sq", P - 256'd1, 256'd2, 1000, 0);
        check("pm1_sq_const", R, 256'd1);

        do_op("two_pow5", 256'd2, 256'd5, 0, 0);
        check("two_pow5_const", R, 256'h20);

        do_op("three_pow0", 256'd3, 256'd0, 0, 0);
        check("three_pow0_const", R, 256'd1);

        do_op("zero_pow7", 256'd0, 256'd7, 0, 0);
        check("zero_pow7_const", R, 256'd0);

        do_op("p_plus1", P + 256'd1, {256{1'b1}}, 0, 0);
        check("p_plus1_const", R, 256'd1);

        // Abort mid-operation, then start in the first cycle after reset release
        @(negedge clk);
        do_op("abort", 256'd5, 256'd11, 0, 5000);
        do_op("after_rst", 256'd2, P - 256'd2, 0, 0);
        check("after_rst_const", R, INV2);
        check("after_rst_times_a", mulmod(R, 256'd2), 256'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp.md
MOD_EXP -- requirements
Module: mod_exp

Interface
REQ-001 Parameter P, default 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F (secp256k1 prime), field modulus.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  256  base; sampled on accepted start.
REQ-006 E  input  256  exponent; sampled on accepted start.
REQ-007 R  output  256  result A^E mod P.
REQ-008 done  output  1  one-cycle pulse when R is valid.
REQ-009 busy  output  1  high while an operation is in progress.

Function
REQ-010 The block SHALL compute R = A^E mod P using left-to-right square-and-multiply over all 256 bits of E, MSB first.
REQ-011 At acceptance: acc=1, bit index=255, A reduced once (A-P if A>=P).
REQ-012 Per bit: acc=acc*acc mod P, then t=acc*A mod P; the multiply SHALL always execute, and acc=t only if E[i]=1.
REQ-013 FSM states: IDLE, SQR_GO, SQR_WAIT, MUL_GO, MUL_WAIT, FIN.
REQ-014 Transitions: IDLE->SQR_GO on start. SQR_GO->SQR_WAIT. SQR_WAIT->MUL_GO on mul done. MUL_GO->MUL_WAIT. MUL_WAIT->SQR_GO on mul done with index>0, decrementing index. MUL_WAIT->FIN on mul done with index=0. FIN->IDLE.
REQ-015 *_GO states SHALL pulse the multiplier start for exactly one cycle; *_WAIT SHALL capture the product in the cycle mul done is high.
REQ-016 Multiplier latency: done high exactly 257 cycles after its start cycle, so each multiply costs 258 cycles.
REQ-017 Latency SHALL be constant and independent of A and E: done high exactly 132097 cycles after the cycle start is sampled in IDLE.
REQ-018 In FIN: done=1 and R=acc; R SHALL hold until the next FIN or reset.
REQ-019 busy SHALL be 1 from the cycle after acceptance through the FIN cycle inclusive.
REQ-020 start while busy SHALL be ignored; A and E changing mid-operation SHALL not affect the result.
REQ-021 E=0 SHALL give R=1, including A=0; A=0 (or A=P) with E!=0 SHALL give R=0.
REQ-022 All intermediate values SHALL stay below P; additions use 257-bit width with conditional subtract.

Reset
REQ-023 When rst=1 at a clock edge: state=IDLE, R=0, done=0, busy=0, multiplier idle; this SHALL hold regardless of current state.
REQ-024 An in-flight operation SHALL be abandoned on reset with no done pulse; a start in the first cycle after reset release SHALL be accepted.

Structure
REQ-025 A shared package SHALL hold P, MUL_LATENCY=257, EXP_LATENCY=132097 and the FSM state encoding, for reuse by mod_inv via E=P-2.
REQ-026 One sub-module, mod_exp_mul, SHALL implement interleaved shift-add modular multiplication.
REQ-027 mod_exp_mul timing: one bit of B per cycle, MSB first, r=2r mod P then +A mod P if bit set; 256 iteration cycles plus 1 finalize cycle.
REQ-028 mod_exp_mul SHALL share clk and rst and use the same start/done pulse handshake.

Verification
REQ-029 A=2, E=P-2 -> R=7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18, done exactly 132097 cycles after start.
REQ-030 A=P-1, E=2 -> R=1. A=2, E=5 -> R=0x20. A=3, E=0 -> R=1. A=0, E=7 -> R=0.
REQ-031 A=P+1 (reduced to 1), E=FF..FF -> R=1; latency identical to REQ-029.
REQ-032 Start pulsed again at cycle 1000 of an operation with different A and E -> ignored, first result unchanged, exactly one done.
REQ-033 rst asserted at cycle 5000 -> next cycle R=0, busy=0, no done; a new start A=2, E=P-2 then completes correctly.
REQ-034 Self-check: feed each inverse into an independent mod multiplier with A -> product SHALL be 1.
